// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state encoding and default parameters for the frequency meter
package freq_meter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } state_e;

  localparam int unsigned DEF_GATE_CYCLES = 100_000_000;
  localparam int unsigned DEF_CNT_W       = 28;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// rtl/freq_meter_sync_edge_det.sv - input synchroniser with rise/fall detection
module freq_meter_sync_edge_det
  import freq_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_in,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  // synchroniser chain plus one delay flop for the edge compare
  always_ff @(posedge clk) begin
    if (rst_in) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge counter plus period and high-time meter
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] edge_count,
  output logic             cnt_valid,
  output logic             overflow,
  output logic             busy,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             per_valid
);

  localparam int unsigned      GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             s;
  logic             rise;
  logic             fall;
  state_e           state_q;
  state_e           state_d;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf;
  logic             gate_last;
  logic             go;
  logic             edge_sat;
  logic [CNT_W-1:0] edge_sum;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic             have_edge;

  freq_meter_sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_in(rst_in),
    .sig_in(sig_in),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  assign go        = start | cont;
  assign gate_last = (state_q == ST_GATE) && (gate_cnt == GATE_LAST);
  // a rise arriving while the counter is already full is the one that gets lost
  assign edge_sat  = rise & (edge_cnt == CNT_MAX);
  assign edge_sum  = edge_sat ? CNT_MAX : edge_cnt + CNT_W'(rise);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: final gate cycle either rolls straight into a new gate or returns to idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = ST_GATE;
      ST_GATE: if (gate_last && !go) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ST_GATE);
  end

  // gate timer and edge counter; results latched on the final gate cycle
  always_ff @(posedge clk) begin
    if (rst_in) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      edge_count <= '0;
      overflow   <= 1'b0;
      cnt_valid  <= 1'b0;
    end else begin
      cnt_valid <= 1'b0;
      if (state_q == ST_IDLE) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        ovf      <= 1'b0;
      end else if (gate_last) begin
        edge_count <= edge_sum;
        overflow   <= ovf | edge_sat;
        cnt_valid  <= 1'b1;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        ovf        <= 1'b0;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        if (rise) begin
          if (edge_cnt == CNT_MAX) ovf <= 1'b1;
          else                     edge_cnt <= edge_cnt + 1'b1;
        end
      end
    end
  end

  // free-running period and high-time measurement, independent of the gate FSM
  always_ff @(posedge clk) begin
    if (rst_in) begin
      per_cnt   <= '0;
      hi_cnt    <= '0;
      have_edge <= 1'b0;
      period    <= '0;
      high_time <= '0;
      per_valid <= 1'b0;
    end else begin
      per_valid <= 1'b0;
      if (rise) begin
        per_cnt   <= CNT_W'(1);
        hi_cnt    <= CNT_W'(1);
        have_edge <= 1'b1;
        if (have_edge) begin
          period    <= per_cnt;
          per_valid <= 1'b1;
        end
      end else begin
        if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 1'b1;
        if (s && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + 1'b1;
      end
      if (fall) high_time <= hi_cnt;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - self-checking bench for freq_meter
module tb_freq_meter;

  logic        clk;
  logic        rst;
  logic        sig;
  logic        start;
  logic        cont;
  logic [27:0] edge_count;
  logic        cnt_valid;
  logic        overflow;
  logic        busy;
  logic [27:0] period;
  logic [27:0] high_time;
  logic        per_valid;

  logic        sig_s;
  logic        start_s;
  logic        cont_s;
  logic [3:0]  edge_count_s;
  logic        cnt_valid_s;
  logic        overflow_s;
  logic        busy_s;
  logic [3:0]  period_s;
  logic [3:0]  high_time_s;
  logic        per_valid_s;

  int mode;
  int mode_s;
  int n_cmp;
  int n_err;
  int cyc;

  typedef struct {
    logic [27:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   cv_times[$];

  freq_meter #(.GATE_CYCLES(1000), .CNT_W(28), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst_in(rst), .sig_in(sig), .start(start), .cont(cont),
    .edge_count(edge_count), .cnt_valid(cnt_valid), .overflow(overflow), .busy(busy),
    .period(period), .high_time(high_time), .per_valid(per_valid)
  );

  freq_meter #(.GATE_CYCLES(200), .CNT_W(4), .SYNC_STAGES(2)) u_small (
    .clk(clk), .rst_in(rst), .sig_in(sig_s), .start(start_s), .cont(cont_s),
    .edge_count(edge_count_s), .cnt_valid(cnt_valid_s), .overflow(overflow_s), .busy(busy_s),
    .period(period_s), .high_time(high_time_s), .per_valid(per_valid_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    logic ok;
    ok = !$isunknown(obs) && (obs >= 32'(lo)) && (obs <= 32'(hi));
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // main signal source: 0 = low, 1 = clk/20 square, 2 = jittered async 40-cycle 30% duty
  initial begin
    int div_cnt;
    int j1;
    int j2;
    div_cnt = 0;
    sig = 1'b0;
    forever begin
      if (mode == 1) begin
        @(negedge clk);
        div_cnt++;
        if (div_cnt >= 10) begin
          div_cnt = 0;
          sig = ~sig;
        end
      end else if (mode == 2) begin
        j1 = $urandom_range(1, 4) + 5 * $urandom_range(0, 1);
        j2 = $urandom_range(1, 4) + 5 * $urandom_range(0, 1);
        #(j1);
        sig = 1'b1;
        #(120 + j2 - j1);
        sig = 1'b0;
        #(400 - 120 - j2);
      end else begin
        sig = 1'b0;
        @(negedge clk);
      end
    end
  end

  // small-DUT source: 0 = low, 1 = clk/4 square
  initial begin
    int dcnt;
    dcnt = 0;
    sig_s = 1'b0;
    forever begin
      @(negedge clk);
      if (mode_s == 1) begin
        dcnt++;
        if (dcnt >= 2) begin
          dcnt = 0;
          sig_s = ~sig_s;
        end
      end else begin
        sig_s = 1'b0;
      end
    end
  end

  // scoreboard: every cnt_valid pops one expected gate result
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (cnt_valid === 1'b1) begin
      cv_times.push_back(cyc);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_cnt_valid: observed edge_count %0d expected no pulse", edge_count);
      end else begin
        e = sb_q.pop_front();
        check("edge_count", 32'(edge_count), 32'(e.cnt));
        check("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    int busy_n;
    int n0;
    bit ok;
    bit dropped;
    int pv_n;
    bit sig_prev;
    exp_t e;

    cyc = 0; n_cmp = 0; n_err = 0;
    mode = 0; mode_s = 0;
    rst = 1'b1; start = 1'b0; cont = 1'b0; start_s = 1'b0; cont_s = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_edge_count", 32'(edge_count), 0);
    check("rst_cnt_valid", 32'(cnt_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_period", 32'(period), 0);
    check("rst_high_time", 32'(high_time), 0);
    check("rst_per_valid", 32'(per_valid), 0);
    check("rst_small_busy", 32'(busy_s), 0);
    rst = 1'b0;

    // single gate on a clk/20 source
    mode = 1;
    repeat (60) @(negedge clk);
    e.cnt = 28'd50; e.ovf = 1'b0;
    sb_q.push_back(e);
    n0 = cv_times.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 1100; i++) begin
      if (busy) busy_n++;
      @(negedge clk);
    end
    check("t1_busy_cycles", 32'(busy_n), 1000);
    check("t1_cnt_valid_pulses", 32'(cv_times.size() - n0), 1);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (per_valid) begin ok = 1; break; end
    end
    check("t1_per_valid_seen", 32'(ok), 1);
    check("t1_period", 32'(period), 20);
    check("t1_high_time", 32'(high_time), 10);

    // continuous mode: three back-to-back gates, then cont drops mid third gate
    for (int k = 0; k < 3; k++) sb_q.push_back(e);
    n0 = cv_times.size();
    cont = 1'b1;
    @(negedge clk);
    dropped = 0;
    for (int i = 0; i < 3100; i++) begin
      if (i < 3000 && !busy) dropped = 1;
      if (i == 2500) cont = 1'b0;
      @(negedge clk);
    end
    check("t2_busy_never_dropped", 32'(dropped), 0);
    check("t2_busy_after", 32'(busy), 0);
    check("t2_cnt_valid_pulses", 32'(cv_times.size() - n0), 3);
    if (cv_times.size() - n0 == 3) begin
      check("t2_spacing_1", 32'(cv_times[n0+1] - cv_times[n0]), 1000);
      check("t2_spacing_2", 32'(cv_times[n0+2] - cv_times[n0+1]), 1000);
    end

    // start on the final gate cycle restarts; start mid-gate is ignored
    sb_q.push_back(e);
    sb_q.push_back(e);
    n0 = cv_times.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (999) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_busy_restart", 32'(busy), 1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (988) @(negedge clk);
    check("t5_busy_last_cycle", 32'(busy), 1);
    @(negedge clk);
    check("t5_busy_end", 32'(busy), 0);
    repeat (5) @(negedge clk);
    check("t5_cnt_valid_pulses", 32'(cv_times.size() - n0), 2);

    // saturation on a 4-bit meter, then an idle gate clears it
    mode_s = 1;
    repeat (20) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cnt_valid_s) begin ok = 1; break; end
    end
    check("t3_cnt_valid_seen", 32'(ok), 1);
    check("t3_edge_count_sat", 32'(edge_count_s), 15);
    check("t3_overflow", 32'(overflow_s), 1);
    check("t3_period", 32'(period_s), 4);
    mode_s = 0;
    repeat (20) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cnt_valid_s) begin ok = 1; break; end
    end
    check("t3_idle_cnt_valid_seen", 32'(ok), 1);
    check("t3_idle_edge_count", 32'(edge_count_s), 0);
    check("t3_idle_overflow", 32'(overflow_s), 0);

    // reset in the middle of a gate, timed just after a falling edge of sig
    n0 = cv_times.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (490) @(negedge clk);
    sig_prev = sig;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (sig_prev && !sig) begin ok = 1; break; end
      sig_prev = sig;
    end
    check("t4_fall_found", 32'(ok), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_edge_count", 32'(edge_count), 0);
    check("t4_cnt_valid", 32'(cnt_valid), 0);
    check("t4_overflow", 32'(overflow), 0);
    check("t4_busy", 32'(busy), 0);
    check("t4_period", 32'(period), 0);
    check("t4_high_time", 32'(high_time), 0);
    check("t4_per_valid", 32'(per_valid), 0);
    pv_n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (per_valid) pv_n++;
    end
    check("t4_no_per_valid_first_rise", 32'(pv_n), 0);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (per_valid) begin ok = 1; break; end
    end
    check("t4_per_valid_second_rise", 32'(ok), 1);
    check("t4_period", 32'(period), 20);
    repeat (1100) @(negedge clk);
    check("t4_no_cnt_valid", 32'(cv_times.size() - n0), 0);

    // asynchronous jittered source, 40-cycle period with 30% duty
    mode = 2;
    repeat (200) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      ok = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (per_valid) begin ok = 1; break; end
      end
      check("t6_per_valid_seen", 32'(ok), 1);
      check_rng("t6_period", 32'(period), 39, 41);
      check_rng("t6_high_time", 32'(high_time), 11, 13);
    end

    mode = 0;
    repeat (10) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
